// File: rtl/edge_delay_measurer.sv
// Measures the delay, in clock cycles, from a rising edge on start to the next rising edge on stop.
// Single-shot or continuously re-arming; a bounded window reports a timeout when stop never arrives.
module edge_delay_measurer #(
    parameter int COUNTER_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CONTINUOUS     = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     start,
    input  logic                     stop,
    output logic                     busy,
    output logic [COUNTER_WIDTH-1:0] result,
    output logic                     result_valid,
    output logic                     timeout
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COUNTING
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_VAL = COUNTER_WIDTH'(TIMEOUT_CYCLES);
    localparam state_t DONE_STATE = (CONTINUOUS != 0) ? ARMED : IDLE;

    state_t                   state, state_n;
    logic [COUNTER_WIDTH-1:0] counter, counter_n;
    logic [COUNTER_WIDTH-1:0] result_n;
    logic                     valid_n, timeout_n;
    logic                     start_d, stop_d;
    logic                     start_edge, stop_edge;

    assign start_edge = start & ~start_d;
    assign stop_edge  = stop & ~stop_d;

    // Edge history resets high so a level already asserted through reset is not an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            counter      <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            start_d      <= 1'b1;
            stop_d       <= 1'b1;
        end else begin
            state        <= state_n;
            counter      <= counter_n;
            result       <= result_n;
            result_valid <= valid_n;
            timeout      <= timeout_n;
            start_d      <= start;
            stop_d       <= stop;
        end
    end

    always_comb begin
        state_n   = state;
        counter_n = counter;
        result_n  = result;
        valid_n   = 1'b0;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                if (arm) state_n = ARMED;
            end
            ARMED: begin
                if (start_edge) begin
                    if (stop_edge) begin
                        result_n = '0;
                        valid_n  = 1'b1;
                        state_n  = DONE_STATE;
                    end else begin
                        counter_n = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
                        state_n   = COUNTING;
                    end
                end
            end
            COUNTING: begin
                // stop wins over timeout when both land on the final cycle
                if (stop_edge) begin
                    result_n = counter;
                    valid_n  = 1'b1;
                    state_n  = DONE_STATE;
                end else if (counter == TIMEOUT_VAL) begin
                    timeout_n = 1'b1;
                    state_n   = DONE_STATE;
                end else begin
                    counter_n = counter + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_edge_delay_measurer.sv
// Scoreboard bench: single-shot and continuous instances, each with a 20-cycle timeout window.
module tb_edge_delay_measurer;

    typedef struct {
        logic        to;
        logic [15:0] res;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        arm_s = 1'b0, start_s = 1'b0, stop_s = 1'b0;
    logic        arm_c = 1'b0, start_c = 1'b0, stop_c = 1'b0;
    logic        busy_s, valid_s, timeout_s;
    logic        busy_c, valid_c, timeout_c;
    logic [15:0] result_s, result_c;

    int   errors = 0;
    int   checks = 0;
    exp_t sq[$];
    exp_t cq[$];

    always #5 clock = ~clock;

    edge_delay_measurer #(.COUNTER_WIDTH(16), .TIMEOUT_CYCLES(20), .CONTINUOUS(0)) dut_s (
        .clock(clock), .reset(reset), .arm(arm_s), .start(start_s), .stop(stop_s),
        .busy(busy_s), .result(result_s), .result_valid(valid_s), .timeout(timeout_s)
    );

    edge_delay_measurer #(.COUNTER_WIDTH(16), .TIMEOUT_CYCLES(20), .CONTINUOUS(1)) dut_c (
        .clock(clock), .reset(reset), .arm(arm_c), .start(start_c), .stop(stop_c),
        .busy(busy_c), .result(result_c), .result_valid(valid_c), .timeout(timeout_c)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Scoreboard: every pulse pops one expectation; a pulse with nothing expected is an error.
    always @(negedge clock) begin
        if (valid_s || timeout_s) begin
            checks++;
            if (valid_s && timeout_s) begin
                errors++;
                $display("FAIL s_exclusive: valid=%b timeout=%b, required not both", valid_s, timeout_s);
            end else if (sq.size() == 0) begin
                errors++;
                $display("FAIL s_unexpected: valid=%b timeout=%b result=%0d, required no pulse", valid_s, timeout_s, result_s);
            end else begin
                exp_t e;
                e = sq.pop_front();
                if (timeout_s !== e.to || result_s !== e.res) begin
                    errors++;
                    $display("FAIL s_scoreboard: timeout=%b result=%0d, required timeout=%b result=%0d", timeout_s, result_s, e.to, e.res);
                end
            end
        end
        if (valid_c || timeout_c) begin
            checks++;
            if (valid_c && timeout_c) begin
                errors++;
                $display("FAIL c_exclusive: valid=%b timeout=%b, required not both", valid_c, timeout_c);
            end else if (cq.size() == 0) begin
                errors++;
                $display("FAIL c_unexpected: valid=%b timeout=%b result=%0d, required no pulse", valid_c, timeout_c, result_c);
            end else begin
                exp_t e;
                e = cq.pop_front();
                if (timeout_c !== e.to || result_c !== e.res) begin
                    errors++;
                    $display("FAIL c_scoreboard: timeout=%b result=%0d, required timeout=%b result=%0d", timeout_c, result_c, e.to, e.res);
                end
            end
        end
    end

    task automatic test_reset;
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(1);
        checks++;
        if ({busy_s, valid_s, timeout_s, result_s} !== 19'd0) begin
            errors++;
            $display("FAIL reset_s: busy=%b valid=%b timeout=%b result=%0d, required all 0", busy_s, valid_s, timeout_s, result_s);
        end
        checks++;
        if ({busy_c, valid_c, timeout_c, result_c} !== 19'd0) begin
            errors++;
            $display("FAIL reset_c: busy=%b valid=%b timeout=%b result=%0d, required all 0", busy_c, valid_c, timeout_c, result_c);
        end
    endtask

    task automatic test_basic;
        arm_s = 1'b1;
        step(1);
        arm_s = 1'b0;
        checks++;
        if (busy_s !== 1'b1) begin
            errors++;
            $display("FAIL basic_armed: busy=%b, required 1", busy_s);
        end
        start_s = 1'b1;
        sq.push_back('{to: 1'b0, res: 16'd7});
        step(7);
        stop_s = 1'b1;
        step(1);
        checks++;
        if (valid_s !== 1'b1 || result_s !== 16'd7 || busy_s !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: valid=%b result=%0d busy=%b, required 1 7 0", valid_s, result_s, busy_s);
        end
        step(1);
        checks++;
        if (valid_s !== 1'b0 || result_s !== 16'd7) begin
            errors++;
            $display("FAIL basic_pulse_hold: valid=%b result=%0d, required 0 7", valid_s, result_s);
        end
        start_s = 1'b0;
        stop_s  = 1'b0;
        step(2);
    endtask

    task automatic test_same_cycle;
        arm_s = 1'b1;
        step(1);
        arm_s   = 1'b0;
        start_s = 1'b1;
        stop_s  = 1'b1;
        sq.push_back('{to: 1'b0, res: 16'd0});
        step(1);
        checks++;
        if (valid_s !== 1'b1 || result_s !== 16'd0 || busy_s !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle: valid=%b result=%0d busy=%b, required 1 0 0", valid_s, result_s, busy_s);
        end
        start_s = 1'b0;
        stop_s  = 1'b0;
        step(2);
    endtask

    task automatic test_timeout;
        arm_s = 1'b1;
        step(1);
        arm_s   = 1'b0;
        start_s = 1'b1;
        sq.push_back('{to: 1'b1, res: 16'd0});
        step(20);
        checks++;
        if (timeout_s !== 1'b0 || busy_s !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: timeout=%b busy=%b, required 0 1", timeout_s, busy_s);
        end
        step(1);
        checks++;
        if (timeout_s !== 1'b1 || valid_s !== 1'b0 || result_s !== 16'd0 || busy_s !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: timeout=%b valid=%b result=%0d busy=%b, required 1 0 0 0", timeout_s, valid_s, result_s, busy_s);
        end
        step(1);
        checks++;
        if (timeout_s !== 1'b0) begin
            errors++;
            $display("FAIL timeout_width: timeout=%b, required 0", timeout_s);
        end
        start_s = 1'b0;
        step(2);
    endtask

    // arm held high across the whole window: ignored until the FSM is back in IDLE
    task automatic test_boundary;
        arm_s = 1'b1;
        step(1);
        start_s = 1'b1;
        sq.push_back('{to: 1'b0, res: 16'd20});
        step(20);
        stop_s = 1'b1;
        step(1);
        checks++;
        if (valid_s !== 1'b1 || timeout_s !== 1'b0 || result_s !== 16'd20 || busy_s !== 1'b0) begin
            errors++;
            $display("FAIL boundary: valid=%b timeout=%b result=%0d busy=%b, required 1 0 20 0", valid_s, timeout_s, result_s, busy_s);
        end
        step(1);
        checks++;
        if (busy_s !== 1'b1) begin
            errors++;
            $display("FAIL boundary_rearm: busy=%b, required 1", busy_s);
        end
        arm_s   = 1'b0;
        start_s = 1'b0;
        stop_s  = 1'b0;
        step(2);
    endtask

    task automatic test_continuous;
        int delays[3] = '{3, 5, 1};
        arm_c = 1'b1;
        step(1);
        arm_c = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_c = 1'b1;
            cq.push_back('{to: 1'b0, res: 16'(delays[i])});
            step(delays[i]);
            stop_c = 1'b1;
            step(1);
            checks++;
            if (valid_c !== 1'b1 || result_c !== 16'(delays[i]) || busy_c !== 1'b1) begin
                errors++;
                $display("FAIL continuous_%0d: valid=%b result=%0d busy=%b, required 1 %0d 1", i, valid_c, result_c, busy_c, delays[i]);
            end
            start_c = 1'b0;
            stop_c  = 1'b0;
            step(1);
        end
    endtask

    task automatic test_reset_abort;
        start_s = 1'b1;
        stop_s  = 1'b1;
        reset   = 1'b1;
        step(2);
        reset = 1'b0;
        arm_s = 1'b1;
        step(1);
        arm_s = 1'b0;
        step(3);
        checks++;
        if (busy_s !== 1'b1 || valid_s !== 1'b0) begin
            errors++;
            $display("FAIL held_level: busy=%b valid=%b, required 1 0", busy_s, valid_s);
        end
        start_s = 1'b0;
        stop_s  = 1'b0;
        step(1);
        start_s = 1'b1;
        step(4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checks++;
        if (busy_s !== 1'b0 || valid_s !== 1'b0 || timeout_s !== 1'b0 || result_s !== 16'd0) begin
            errors++;
            $display("FAIL abort: busy=%b valid=%b timeout=%b result=%0d, required 0 0 0 0", busy_s, valid_s, timeout_s, result_s);
        end
        start_s = 1'b0;
        step(1);
        arm_s = 1'b1;
        step(1);
        arm_s   = 1'b0;
        start_s = 1'b1;
        sq.push_back('{to: 1'b0, res: 16'd2});
        step(2);
        stop_s = 1'b1;
        step(1);
        checks++;
        if (valid_s !== 1'b1 || result_s !== 16'd2) begin
            errors++;
            $display("FAIL after_abort: valid=%b result=%0d, required 1 2", valid_s, result_s);
        end
        start_s = 1'b0;
        stop_s  = 1'b0;
        step(2);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_same_cycle;
        test_timeout;
        test_boundary;
        test_continuous;
        test_reset_abort;
        step(5);
        checks++;
        if (sq.size() != 0 || cq.size() != 0) begin
            errors++;
            $display("FAIL drain: pending s=%0d c=%0d, required 0 0", sq.size(), cq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
